// File: rtl/taxi_mode_ctrl_pkg.sv
// Shared taximeter definitions: mode codes (also used by the light decoder) and accumulator widths.
package taxi_mode_ctrl_pkg;

    typedef enum logic [1:0] {
        MODE_VACANT = 2'd0,
        MODE_RUN    = 2'd1,
        MODE_WAIT   = 2'd2,
        MODE_SETTLE = 2'd3
    } mode_e;

    localparam int unsigned WAIT_SEC_W = 8;
    localparam logic [WAIT_SEC_W-1:0] WAIT_SEC_MAX = '1;
    localparam logic [WAIT_SEC_W-1:0] WAIT_SEC_ONE = 1;

endpackage

// File: rtl/taxi_mode_ctrl_if.sv
// Button/sensor inputs and mode/enable outputs of the taximeter mode controller.
interface taxi_mode_ctrl_if;
    import taxi_mode_ctrl_pkg::*;

    logic                  sec_tick;
    logic                  btn_start;
    logic                  btn_stop;
    logic                  wheel_pulse;
    logic [1:0]            light;
    logic                  dist_en;
    logic                  wait_en;
    logic                  fare_clr;
    logic [WAIT_SEC_W-1:0] wait_sec;

    modport master (
        output sec_tick, btn_start, btn_stop, wheel_pulse,
        input  light, dist_en, wait_en, fare_clr, wait_sec
    );

    modport slave (
        input  sec_tick, btn_start, btn_stop, wheel_pulse,
        output light, dist_en, wait_en, fare_clr, wait_sec
    );

endinterface

// File: rtl/taxi_mode_ctrl_sec_down_timer.sv
// 4-bit loadable second timer: load restarts the interval, expire flags the tick that completes it.
// Latency: expire is combinational on the completing tick; load beats tick in the same cycle.
module sec_down_timer #(
    parameter logic [3:0] LIMIT = 4'd1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic tick,
    output logic expire
);

    // rem counts the seconds still to go; elapsed count is LIMIT - rem
    logic [3:0] rem;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem <= LIMIT;
        end else if (load) begin
            rem <= LIMIT;
        end else if (tick && rem != 4'd0) begin
            rem <= rem - 4'd1;
        end
    end

    assign expire = tick & ~load & (rem == 4'd1);

endmodule

// File: rtl/taxi_mode_ctrl.sv
// Taximeter mode sequencer (VACANT/RUN/WAIT/SETTLE) driving light code, fare enables and wait_sec.
// Latency: all outputs registered, 1 cycle after the sampling edge; no backpressure, inputs are pulses.
module taxi_mode_ctrl
    import taxi_mode_ctrl_pkg::*;
#(
    parameter int unsigned WAIT_TIMEOUT_S = 5,
    parameter int unsigned SETTLE_S       = 10
) (
    input  logic            clk,
    input  logic            rst_n,
    taxi_mode_ctrl_if.slave tm
);

    // Assert asynchronously, release two edges later in step with clk
    logic [1:0] rst_sync;
    logic       rst_core_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync <= 2'b00;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_core_n = rst_sync[1];

    mode_e                 state_q, state_d;
    logic                  dist_en_q, dist_en_d;
    logic                  wait_en_q, wait_en_d;
    logic                  fare_clr_q, fare_clr_d;
    logic [WAIT_SEC_W-1:0] wait_sec_q, wait_sec_d;
    logic                  idle_load, idle_expire;
    logic                  settle_load, settle_expire;

    // Timers sit loaded outside their state, so every entry starts from zero
    assign idle_load   = (state_q != MODE_RUN) | tm.wheel_pulse;
    assign settle_load = (state_q != MODE_SETTLE);

    sec_down_timer #(.LIMIT(4'(WAIT_TIMEOUT_S))) u_idle_tmr (
        .clk    (clk),
        .rst_n  (rst_core_n),
        .load   (idle_load),
        .tick   (tm.sec_tick),
        .expire (idle_expire)
    );

    sec_down_timer #(.LIMIT(4'(SETTLE_S))) u_settle_tmr (
        .clk    (clk),
        .rst_n  (rst_core_n),
        .load   (settle_load),
        .tick   (tm.sec_tick),
        .expire (settle_expire)
    );

    always_ff @(posedge clk or negedge rst_core_n) begin
        if (!rst_core_n) begin
            state_q    <= MODE_VACANT;
            dist_en_q  <= 1'b0;
            wait_en_q  <= 1'b0;
            fare_clr_q <= 1'b0;
            wait_sec_q <= '0;
        end else begin
            state_q    <= state_d;
            dist_en_q  <= dist_en_d;
            wait_en_q  <= wait_en_d;
            fare_clr_q <= fare_clr_d;
            wait_sec_q <= wait_sec_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        fare_clr_d = 1'b0;
        wait_sec_d = wait_sec_q;
        case (state_q)
            MODE_VACANT: begin
                if (tm.btn_start) begin
                    state_d    = MODE_RUN;
                    fare_clr_d = 1'b1;
                    wait_sec_d = '0;
                end
            end
            MODE_RUN: begin
                if (tm.btn_stop)       state_d = MODE_SETTLE;
                else if (idle_expire)  state_d = MODE_WAIT;
            end
            MODE_WAIT: begin
                if (tm.sec_tick && wait_sec_q != WAIT_SEC_MAX)
                    wait_sec_d = wait_sec_q + WAIT_SEC_ONE;
                if (tm.btn_stop)         state_d = MODE_SETTLE;
                else if (tm.wheel_pulse) state_d = MODE_RUN;
            end
            MODE_SETTLE: begin
                if (tm.btn_start) begin
                    state_d    = MODE_RUN;
                    fare_clr_d = 1'b1;
                    wait_sec_d = '0;
                end else if (settle_expire) begin
                    state_d = MODE_VACANT;
                end
            end
            default: state_d = MODE_VACANT;
        endcase
        dist_en_d = (state_d == MODE_RUN);
        wait_en_d = (state_d == MODE_WAIT);
    end

    assign tm.light    = state_q;
    assign tm.dist_en  = dist_en_q;
    assign tm.wait_en  = wait_en_q;
    assign tm.fare_clr = fare_clr_q;
    assign tm.wait_sec = wait_sec_q;

endmodule

// File: tb/tb_taxi_mode_ctrl.sv
// Directed vector bench for taxi_mode_ctrl with WAIT_TIMEOUT_S=3, SETTLE_S=2.
module tb_taxi_mode_ctrl;

    typedef struct {
        logic       tick, start, stop, wheel;
        logic [1:0] lt;
        logic       d, w, f;
        logic [7:0] ws;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_pass = 0;
    vec_t tbl[$];

    taxi_mode_ctrl_if tm ();

    taxi_mode_ctrl #(.WAIT_TIMEOUT_S(3), .SETTLE_S(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .tm    (tm)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic chk_all(input string tag, input int lt, input int d, input int w,
                           input int f, input int ws);
        chk({tag, " light"},    int'(tm.light),    lt);
        chk({tag, " dist_en"},  int'(tm.dist_en),  d);
        chk({tag, " wait_en"},  int'(tm.wait_en),  w);
        chk({tag, " fare_clr"}, int'(tm.fare_clr), f);
        chk({tag, " wait_sec"}, int'(tm.wait_sec), ws);
    endtask

    // Called at a negedge: drive, let one posedge sample, return at next negedge with inputs idle
    task automatic cyc(input logic tick, input logic start, input logic stop, input logic wheel);
        tm.sec_tick    = tick;
        tm.btn_start   = start;
        tm.btn_stop    = stop;
        tm.wheel_pulse = wheel;
        @(posedge clk);
        @(negedge clk);
        tm.sec_tick    = 1'b0;
        tm.btn_start   = 1'b0;
        tm.btn_stop    = 1'b0;
        tm.wheel_pulse = 1'b0;
    endtask

    task automatic add(input logic tick, input logic start, input logic stop, input logic wheel,
                       input logic [1:0] lt, input logic d, input logic w, input logic f,
                       input logic [7:0] ws);
        vec_t v;
        v.tick = tick; v.start = start; v.stop = stop; v.wheel = wheel;
        v.lt = lt; v.d = d; v.w = w; v.f = f; v.ws = ws;
        tbl.push_back(v);
    endtask

    initial begin
        tm.sec_tick = 1'b0; tm.btn_start = 1'b0; tm.btn_stop = 1'b0; tm.wheel_pulse = 1'b0;

        //   tick st sp wh   light d w f ws
        add(0,0,1,0, 0,0,0,0,0);   // stop ignored in VACANT
        add(0,0,0,1, 0,0,0,0,0);
        add(1,0,0,0, 0,0,0,0,0);
        add(0,1,0,0, 1,1,0,1,0);   // start: fare_clr pulse
        add(0,0,0,0, 1,1,0,0,0);
        add(1,0,0,0, 1,1,0,0,0);   // idle 1
        add(0,0,0,1, 1,1,0,0,0);   // idle 0
        add(1,0,0,0, 1,1,0,0,0);   // idle 1
        add(1,0,0,0, 1,1,0,0,0);   // idle 2
        add(1,0,0,1, 1,1,0,0,0);   // wheel beats tick: idle 0
        add(1,0,0,0, 1,1,0,0,0);
        add(1,0,0,0, 1,1,0,0,0);
        add(1,0,0,0, 2,0,1,0,0);   // 3rd tick: WAIT, tick not counted
        add(1,0,0,0, 2,0,1,0,1);
        add(0,1,0,0, 2,0,1,0,1);   // start ignored in WAIT
        add(1,0,0,0, 2,0,1,0,2);
        add(1,0,0,0, 2,0,1,0,3);
        add(1,0,0,0, 2,0,1,0,4);
        add(0,0,0,1, 1,1,0,0,4);   // resume, wait_sec held
        add(1,0,0,0, 1,1,0,0,4);
        add(0,0,1,0, 3,0,0,0,4);   // stop -> SETTLE
        add(1,0,0,0, 3,0,0,0,4);
        add(0,0,0,1, 3,0,0,0,4);
        add(0,0,1,0, 3,0,0,0,4);
        add(1,0,0,0, 0,0,0,0,4);   // 2nd tick: VACANT, wait_sec kept
        add(0,1,0,0, 1,1,0,1,0);
        add(1,0,0,0, 1,1,0,0,0);
        add(1,0,0,0, 1,1,0,0,0);
        add(1,0,0,0, 2,0,1,0,0);
        add(1,0,0,0, 2,0,1,0,1);
        add(0,0,1,1, 3,0,0,0,1);   // stop beats wheel in WAIT
        add(1,0,0,0, 3,0,0,0,1);
        add(1,1,0,0, 1,1,0,1,0);   // start beats settle timeout
        add(0,0,0,0, 1,1,0,0,0);
        add(1,0,0,0, 1,1,0,0,0);
        add(1,0,0,0, 1,1,0,0,0);
        add(1,0,1,0, 3,0,0,0,0);   // stop beats idle timeout
        add(1,0,0,0, 3,0,0,0,0);
        add(1,0,0,0, 0,0,0,0,0);

        repeat (3) @(negedge clk);
        chk_all("reset_held", 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk_all("after_release", 0, 0, 0, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            cyc(tbl[i].tick, tbl[i].start, tbl[i].stop, tbl[i].wheel);
            chk_all($sformatf("vec%0d", i), int'(tbl[i].lt), int'(tbl[i].d),
                    int'(tbl[i].w), int'(tbl[i].f), int'(tbl[i].ws));
        end

        // Mid-trip reset from WAIT with wait_sec=7
        cyc(0, 1, 0, 0);
        repeat (3) cyc(1, 0, 0, 0);
        repeat (7) cyc(1, 0, 0, 0);
        chk_all("pre_reset", 2, 0, 1, 0, 7);
        #2 rst_n = 1'b0;
        #1 chk_all("async_reset", 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        cyc(1, 0, 0, 1);
        chk_all("post_reset_idle", 0, 0, 0, 0, 0);

        // wait_sec saturation
        cyc(0, 1, 0, 0);
        repeat (3) cyc(1, 0, 0, 0);
        chk_all("sat_enter_wait", 2, 0, 1, 0, 0);
        repeat (300) cyc(1, 0, 0, 0);
        chk_all("sat_300", 2, 0, 1, 0, 255);
        repeat (5) cyc(1, 0, 0, 0);
        chk_all("sat_hold", 2, 0, 1, 0, 255);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
